// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller with variable-latency data-memory port
//
// Purpose:
//   Consumes the EX/MEM fields and runs a data-memory read or write over a
//   req/ack handshake. It stalls upstream while the access is outstanding and
//   abandons the access after TIMEOUT busy cycles. It resolves the branch
//   decision and drives the MEM/WB register.
//
// Optional feature:
//   MEM_ALIGN_CHK_EN - when defined, a misaligned access is dropped: it issues
//   no request, does not stall, inserts a bubble and pulses mem_misalign.
//
// Parameters:
//   TIMEOUT  - busy cycles without dm_ack before the access is abandoned (1..255)
//   BAD_DATA - rd_data value returned on a timed-out read
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   RegWrite .. Zero               EX/MEM control fields
//   b_tgt, alu_out, RD2, rfile_wn  EX/MEM branch target, address/result, store data, dest
//   dm_req/dm_we/dm_addr/dm_wdata  data-memory request (registered, stable while dm_req)
//   dm_ack, dm_rdata               data-memory completion strobe and read data
//   stall                          hold upstream pipeline registers (combinational)
//   PCSrc, pc_tgt                  branch taken and target (combinational)
//   RegWrite_Out .. rfile_wn_Out   MEM/WB register
//   mem_err                        sticky timeout flag
//   mem_misalign                   one-cycle misalignment pulse
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] BAD_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] b_tgt,
  input  logic [31:0] alu_out,
  input  logic [31:0] RD2,
  input  logic [4:0]  rfile_wn,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] pc_tgt,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic [31:0] rd_data,
  output logic [31:0] alu_out_Out,
  output logic [4:0]  rfile_wn_Out,
  output logic        mem_err,
  output logic        mem_misalign
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        dm_req_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [31:0] dm_wdata_q;
  logic        regwrite_out_q;
  logic        memtoreg_out_q;
  logic [31:0] rd_data_q;
  logic [31:0] alu_out_out_q;
  logic [4:0]  rfile_wn_out_q;
  logic        mem_err_q;

  logic pending;
  logic misaligned;
  logic issue;
  logic timeout;
  logic done;
  logic drop;

  assign pending = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = (alu_out[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign issue   = (state_q == IDLE) & pending & ~misaligned;
  // A misaligned access is retired without ever reaching the memory port.
  assign drop    = (state_q == IDLE) & pending & misaligned;
  // Counter holds BUSY-cycle index minus one, so the last allowed cycle is TIMEOUT-1.
  assign timeout = (state_q == BUSY) & ~dm_ack & (cnt_q == CNT_LAST);
  assign done    = (state_q == BUSY) & (dm_ack | timeout);

  assign stall  = issue | ((state_q == BUSY) & ~dm_ack & ~timeout);
  assign PCSrc  = Branch & Zero & ~stall;
  assign pc_tgt = b_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      dm_addr_q      <= 32'd0;
      dm_wdata_q     <= 32'd0;
      regwrite_out_q <= 1'b0;
      memtoreg_out_q <= 1'b0;
      rd_data_q      <= 32'd0;
      alu_out_out_q  <= 32'd0;
      rfile_wn_out_q <= 5'd0;
      mem_err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q    <= BUSY;
            dm_req_q   <= 1'b1;
            dm_we_q    <= MemWrite;
            dm_addr_q  <= alu_out;
            dm_wdata_q <= RD2;
            cnt_q      <= 8'd0;
          end
        end
        BUSY: begin
          if (done) begin
            state_q  <= IDLE;
            dm_req_q <= 1'b0;
            if (!dm_we_q) begin
              rd_data_q <= dm_ack ? dm_rdata : BAD_DATA;
            end
            if (timeout) begin
              mem_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // MEM/WB: bubble the control bits while stalled or on a dropped access.
      if (stall || drop) begin
        regwrite_out_q <= 1'b0;
        memtoreg_out_q <= 1'b0;
      end else begin
        regwrite_out_q <= RegWrite;
        memtoreg_out_q <= MemtoReg;
        alu_out_out_q  <= alu_out;
        rfile_wn_out_q <= rfile_wn;
      end
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  logic mem_misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_misalign_q <= 1'b0;
    end else begin
      mem_misalign_q <= drop;
    end
  end

  assign mem_misalign = mem_misalign_q;
`else
  assign mem_misalign = 1'b0;
`endif

  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;
  assign RegWrite_Out = regwrite_out_q;
  assign MemtoReg_Out = memtoreg_out_q;
  assign rd_data      = rd_data_q;
  assign alu_out_Out  = alu_out_out_q;
  assign rfile_wn_Out = rfile_wn_out_q;
  assign mem_err      = mem_err_q;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the five-stage pipeline: consumes the registered EX/MEM control and data fields, runs data-memory reads and writes over a req/ack handshake, stalls upstream while an access is outstanding, resolves the branch decision, and drives the MEM/WB register. It replaces the single-cycle data-memory assumption with a variable-latency memory port that has a bounded timeout.

## Interface
- TIMEOUT, 15: cycles in BUSY without dm_ack before the access is abandoned (1..255).
- BAD_DATA, 32'hDEADBEEF: rd_data value returned on a timed-out read.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- RegWrite, MemtoReg, MemRead, MemWrite, Branch, Zero  in  1 each  EX/MEM control fields
- b_tgt, alu_out, RD2  in  32 each  EX/MEM branch target, ALU result / address, store data
- rfile_wn  in  5  EX/MEM destination register
- dm_req  out  1  memory request, held until ack or timeout
- dm_we  out  1  1 = write, 0 = read; valid while dm_req
- dm_addr, dm_wdata  out  32 each  latched address and store data
- dm_ack  in  1  one-cycle completion strobe
- dm_rdata  in  32  read data, valid with dm_ack
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- PCSrc  out  1  take branch; pc_tgt valid
- pc_tgt  out  32  equals b_tgt
- RegWrite_Out, MemtoReg_Out  out  1 each  MEM/WB control
- rd_data, alu_out_Out  out  32 each  MEM/WB load data, ALU result
- rfile_wn_Out  out  5  MEM/WB destination
- mem_err  out  1  sticky: a timeout occurred
- mem_misalign  out  1  one-cycle pulse (alignment check only)

## Operation
- An access is pending when MemRead or MemWrite is 1. If both are 1, it is a write.
- FSM has two states: IDLE and BUSY.
  - IDLE with an access pending: stall=1. At the next edge, move to BUSY. Latch dm_addr=alu_out, dm_wdata=RD2 and dm_we=MemWrite. Set dm_req=1 and clear the counter.
  - IDLE with no access pending: stall=0 and the instruction passes through.
  - BUSY with dm_ack=0: stall=1 and the counter increments.
  - BUSY with dm_ack=1: stall=0, dm_req drops at the edge, and the FSM returns to IDLE. On a read, capture dm_rdata into rd_data.
  - BUSY with counter==TIMEOUT-1 and no ack: same as ack, except rd_data=BAD_DATA, mem_err is set, and the write is considered dropped.
- stall = (IDLE & pending) | (BUSY & ~dm_ack & ~timeout). It is combinational.
- MEM/WB update when stall=0: RegWrite_Out, MemtoReg_Out, alu_out_Out and rfile_wn_Out load from the inputs. rd_data loads on reads.
- MEM/WB update when stall=1: RegWrite_Out and MemtoReg_Out load 0 (bubble). All other MEM/WB fields hold.
- PCSrc = Branch & Zero & ~stall. pc_tgt = b_tgt. Both are combinational.
- dm_ack in IDLE is ignored.
- Once set, mem_err is cleared only by rst.

## Timing
- Reset: state=IDLE, counter=0, mem_misalign=0, mem_err=0. All registered outputs are 0: dm_req, dm_we, dm_addr, dm_wdata, RegWrite_Out, MemtoReg_Out, rd_data, alu_out_Out, rfile_wn_Out.
- rst during BUSY aborts the access. dm_req is 0 the cycle after the rst edge, and no MEM/WB write occurs.
- Non-memory instruction: 1 cycle in MEM.
- Memory instruction: 2 cycles minimum (ack on the first BUSY cycle), N+1 cycles for ack on BUSY cycle N, and at most TIMEOUT+1 cycles.
- dm_addr, dm_wdata and dm_we are stable for the whole time dm_req=1.
- A new request is issued no earlier than one cycle after the previous ack.
- Back-to-back accesses: after an ack edge the FSM is in IDLE, and the next pending access stalls one cycle before its request.

## Configuration
- MEM_ALIGN_CHK_EN defined:
  - An access in IDLE with alu_out[1:0]!=0 issues no request and does not stall.
  - mem_misalign pulses 1 for one cycle after the edge.
  - MEM/WB receives a bubble: RegWrite_Out=0.
- MEM_ALIGN_CHK_EN undefined: no alignment check, addresses pass unmodified, and mem_misalign is tied 0.

## Test plan
- Load from alu_out=0x40 with dm_ack on the 3rd BUSY cycle and dm_rdata=0x1234 -> stall high 3 cycles, dm_req high 3 cycles, rd_data=0x1234, MemtoReg_Out=1 on the 4th edge.
- Store RD2=0xCAFE to 0x80 with immediate ack -> dm_we=1, dm_wdata=0xCAFE for 1 cycle, RegWrite_Out=0, stall 1 cycle.
- Load with no ack, TIMEOUT=15 -> dm_req drops after 15 BUSY cycles, rd_data=0xDEADBEEF, mem_err=1 until rst.
- Branch=1 and Zero=1 with b_tgt=0x100 in IDLE -> PCSrc=1 and pc_tgt=0x100 in the same cycle. With Zero=0 -> PCSrc=0.
- rst asserted on the 2nd BUSY cycle -> next cycle: IDLE, dm_req=0, all outputs 0. A late dm_ack is ignored.
- MEM_ALIGN_CHK_EN, load from 0x42 -> no dm_req, stall=0, mem_misalign pulses, RegWrite_Out=0.
